// File: rtl/gmac_tx_chan_arb.sv
// Round-robin N-channel transmit arbiter in front of the single GMAC TX input.
// Forwards the GMAC request/confirm handshake and polices SoF timeout, frame length and IFG.
module gmac_tx_chan_arb #(
  parameter int NCH        = 2,
  parameter int DW         = 8,
  parameter int IFG_CYCLES = 12,
  parameter int SOF_TMO    = 1024,
  parameter int MAX_BEATS  = 1518
) (
  input  logic                     clk125,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           ValIn,
  input  logic [NCH-1:0]           SoFIn,
  input  logic [NCH-1:0]           EoFIn,
  input  logic [NCH-1:0]           ReqIn,
  input  logic [NCH*DW-1:0]        DataIn,
  output logic [NCH-1:0]           ReqConfirm,
  output logic                     ReqOut,
  input  logic                     GmacConfirm,
  output logic                     ValOut,
  output logic                     SoFOut,
  output logic                     EoFOut,
  output logic [DW-1:0]            DataOut,
  output logic [$clog2(NCH)-1:0]   GrantId,
  output logic                     Busy,
  output logic [15:0]              ErrCnt
);

  localparam int IW = $clog2(NCH);
  localparam int TW = $clog2(SOF_TMO + 1);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_LAST = TW'(SOF_TMO - 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BEATS);
  localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_SOF, S_XFER, S_DRAIN, S_GAP
  } state_t;

  localparam state_t AFTER_FRAME = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_grant, w_grant_nxt;
  logic [IW-1:0]   r_rr, w_rr_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [BW-1:0]   r_beats, w_beats_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic            r_req_out, w_req_out_nxt;
  logic [NCH-1:0]  r_req_conf, w_req_conf_nxt;
  logic            r_val, w_val_nxt;
  logic            r_sof, w_sof_nxt;
  logic            r_eof, w_eof_nxt;
  logic [DW-1:0]   r_data, w_data_nxt;
  logic [15:0]     r_err;
  logic            w_err_inc;

  logic            w_any_req;
  logic [IW-1:0]   w_pick;
  logic            w_g_val, w_g_sof, w_g_eof;
  logic [DW-1:0]   w_g_data;
  logic            w_fwd;
  logic [BW-1:0]   w_beat_cnt;

  // Nearest requester after the rr pointer: scan farthest-first so the closest one wins.
  always_comb begin
    logic [IW-1:0] idx;
    w_any_req = 1'b0;
    w_pick    = r_rr;
    for (int k = NCH; k >= 1; k--) begin
      idx = IW'((int'(r_rr) + k) % NCH);
      if (ReqIn[idx]) begin
        w_any_req = 1'b1;
        w_pick    = idx;
      end
    end
  end

  always_comb begin
    w_g_val  = 1'b0;
    w_g_sof  = 1'b0;
    w_g_eof  = 1'b0;
    w_g_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_grant == IW'(c)) begin
        w_g_val  = ValIn[c];
        w_g_sof  = SoFIn[c];
        w_g_eof  = EoFIn[c];
        w_g_data = DataIn[c*DW +: DW];
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_nxt       = r_rr;
    w_timer_nxt    = '0;
    w_beats_nxt    = r_beats;
    w_gap_nxt      = '0;
    w_req_out_nxt  = r_req_out;
    w_req_conf_nxt = '0;
    w_val_nxt      = 1'b0;
    w_sof_nxt      = 1'b0;
    w_eof_nxt      = 1'b0;
    w_data_nxt     = r_data;
    w_err_inc      = 1'b0;
    w_fwd          = 1'b0;
    w_beat_cnt     = (r_state == S_WAIT_SOF) ? BW'(1) : r_beats + BW'(1);

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant_nxt   = w_pick;
          w_rr_nxt      = w_pick;
          w_req_out_nxt = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        if (GmacConfirm) begin
          w_req_out_nxt           = 1'b0;
          w_req_conf_nxt[r_grant] = 1'b1;
          w_state_nxt             = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        if (w_g_val && w_g_sof) begin
          w_fwd = 1'b1;
        end else if (r_timer == TMO_LAST) begin
          w_err_inc   = 1'b1;
          w_state_nxt = AFTER_FRAME;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_XFER: begin
        w_fwd = w_g_val;
      end
      S_DRAIN: begin
        if (w_g_val && w_g_eof) w_state_nxt = AFTER_FRAME;
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = S_IDLE;
        else                   w_gap_nxt   = r_gap + GW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Shared beat forwarding for the first beat (WAIT_SOF) and the body (XFER).
    if (w_fwd) begin
      w_val_nxt   = 1'b1;
      w_sof_nxt   = (r_state == S_WAIT_SOF);
      w_data_nxt  = w_g_data;
      w_beats_nxt = w_beat_cnt;
      if (w_g_eof) begin
        w_eof_nxt   = 1'b1;
        w_state_nxt = AFTER_FRAME;
      end else if (w_beat_cnt == BEAT_MAX) begin
        w_eof_nxt   = 1'b1;
        w_err_inc   = 1'b1;
        w_state_nxt = S_DRAIN;
      end else begin
        w_state_nxt = S_XFER;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr       <= IW'(NCH - 1);
      r_timer    <= '0;
      r_beats    <= '0;
      r_gap      <= '0;
      r_req_out  <= 1'b0;
      r_req_conf <= '0;
      r_val      <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_data     <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr       <= w_rr_nxt;
      r_timer    <= w_timer_nxt;
      r_beats    <= w_beats_nxt;
      r_gap      <= w_gap_nxt;
      r_req_out  <= w_req_out_nxt;
      r_req_conf <= w_req_conf_nxt;
      r_val      <= w_val_nxt;
      r_sof      <= w_sof_nxt;
      r_eof      <= w_eof_nxt;
      r_data     <= w_data_nxt;
      if (w_err_inc && (r_err != 16'hFFFF)) r_err <= r_err + 16'd1;
    end
  end

  assign ReqConfirm = r_req_conf;
  assign ReqOut     = r_req_out;
  assign ValOut     = r_val;
  assign SoFOut     = r_sof;
  assign EoFOut     = r_eof;
  assign DataOut    = r_data;
  assign GrantId    = r_grant;
  assign Busy       = (r_state != S_IDLE);
  assign ErrCnt     = r_err;

endmodule
